// File: rtl/freq_meas_pkg.sv
// Shared constants, types and helpers for the frequency-measurement AXI4-Lite slave.
package freq_meas_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_GATE    = 2'd1;
  localparam logic [1:0] ADDR_RESULT  = 2'd2;
  localparam logic [1:0] ADDR_SCRATCH = 2'd3;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_DONE_BIT = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] GATE_RESET = 32'h0000_0064;

  typedef enum logic {IDLE, RUN} state_e;

  function automatic logic [31:0] apply_strb(logic [31:0] old_v, logic [31:0] new_v,
                                             logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/freq_meas_core.sv
// Gated edge counter: synchronizes f_in, counts rising edges over GATE-cycle windows,
// latches RESULT and pulses done_set_o at every window end.
module freq_meas_core
  import freq_meas_pkg::*;
#(
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [31:0]         gate_i,
  input  logic                f_in_i,
  output logic [CntWidth-1:0] result_o,
  output logic                done_set_o
);

  state_e              state_q, state_d;
  logic [1:0]          sync_q;
  logic                sync_prev_q;
  logic                edge_det;
  logic [31:0]         gate_len;
  logic [31:0]         gate_cnt_q, gate_cnt_d;
  logic [31:0]         gate_win_q, gate_win_d;
  logic [CntWidth-1:0] edge_cnt_q, edge_cnt_d;
  logic [CntWidth-1:0] result_q, result_d;
  logic [CntWidth-1:0] edge_sum;
  logic                run_active, win_end, load_win;

  assign edge_det = sync_q[1] & ~sync_prev_q;
  assign gate_len = (gate_i == '0) ? 32'd1 : gate_i;
  assign edge_sum = (edge_det && edge_cnt_q != '1) ? edge_cnt_q + CntWidth'(1) : edge_cnt_q;
  assign result_o = result_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (en_i) state_d = RUN;
      RUN:  if (!en_i) state_d = IDLE;
    endcase
  end

  // The window length is sampled at window start so GATE writes only affect the next window.
  always_comb begin
    run_active = (state_q == RUN) && en_i;
    win_end    = run_active && (gate_cnt_q == gate_win_q - 32'd1);
    load_win   = ((state_q == IDLE) && en_i) || win_end;
    done_set_o = win_end;
  end

  always_comb begin
    gate_cnt_d = '0;
    edge_cnt_d = '0;
    result_d   = result_q;
    gate_win_d = gate_win_q;
    if (load_win) gate_win_d = gate_len;
    if (win_end) begin
      result_d = edge_sum;
    end else if (run_active) begin
      gate_cnt_d = gate_cnt_q + 32'd1;
      edge_cnt_d = edge_sum;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      gate_cnt_q  <= '0;
      gate_win_q  <= GATE_RESET;
      edge_cnt_q  <= '0;
      result_q    <= '0;
    end else begin
      sync_q      <= {sync_q[0], f_in_i};
      sync_prev_q <= sync_q[1];
      gate_cnt_q  <= gate_cnt_d;
      gate_win_q  <= gate_win_d;
      edge_cnt_q  <= edge_cnt_d;
      result_q    <= result_d;
    end
  end

endmodule

// File: rtl/freq_meas_axil_slave.sv
// AXI4-Lite register front end for the frequency-measurement IP: CTRL, GATE, RESULT, SCRATCH.
module freq_meas_axil_slave
  import freq_meas_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH          = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            f_in,
  output logic                            done_irq
);

  logic                 ready_en_q;
  logic                 aw_held_q, aw_held_d;
  logic [1:0]           aw_addr_q, aw_addr_d;
  logic                 w_held_q, w_held_d;
  logic [31:0]          w_data_q, w_data_d;
  logic [3:0]           w_strb_q, w_strb_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic                 rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 en_q, en_d;
  logic                 done_q, done_d;
  logic [31:0]          gate_q, gate_d;
  logic [31:0]          scratch_q, scratch_d;
  logic [CNT_WIDTH-1:0] result;
  logic [31:0]          result_ext;
  logic [31:0]          ctrl_rd;
  logic                 done_set, done_clr;
  logic                 aw_hs, w_hs, ar_hs, commit;
  logic                 unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  freq_meas_core #(
    .CntWidth (CNT_WIDTH)
  ) u_core (
    .clk_i      (ACLK),
    .rst_i      (ARESET),
    .en_i       (en_q),
    .gate_i     (gate_q),
    .f_in_i     (f_in),
    .result_o   (result),
    .done_set_o (done_set)
  );

  // ready_en_q keeps every READY low while reset is asserted.
  assign S_AXI_AWREADY = ready_en_q & ~aw_held_q;
  assign S_AXI_WREADY  = ready_en_q & ~w_held_q;
  assign S_AXI_ARREADY = ready_en_q & ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign done_irq      = done_q;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_held_q & w_held_q & ~bvalid_q;

  always_comb begin
    result_ext                = '0;
    result_ext[CNT_WIDTH-1:0] = result;
    ctrl_rd                   = '0;
    ctrl_rd[CTRL_EN_BIT]      = en_q;
    ctrl_rd[CTRL_DONE_BIT]    = done_q;
  end

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    en_d      = en_q;
    gate_d    = gate_q;
    scratch_d = scratch_q;
    done_clr  = 1'b0;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = S_AXI_AWADDR[3:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      unique case (aw_addr_q)
        ADDR_CTRL: begin
          if (w_strb_q[0]) en_d = w_data_q[CTRL_EN_BIT];
          done_clr = w_strb_q[1] & w_data_q[CTRL_DONE_BIT];
        end
        ADDR_GATE:    gate_d    = apply_strb(gate_q, w_data_q, w_strb_q);
        ADDR_RESULT:  bresp_d   = RESP_SLVERR;
        ADDR_SCRATCH: scratch_d = apply_strb(scratch_q, w_data_q, w_strb_q);
      endcase
    end
    // A window ending in the same cycle as a W1C keeps DONE set.
    done_d = done_set | (done_q & ~done_clr);
  end

  // Reads sample the registered values, so a same-cycle write is not yet visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      unique case (S_AXI_ARADDR[3:2])
        ADDR_CTRL:    rdata_d = ctrl_rd;
        ADDR_GATE:    rdata_d = gate_q;
        ADDR_RESULT:  rdata_d = result_ext;
        ADDR_SCRATCH: rdata_d = scratch_q;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      gate_q     <= GATE_RESET;
      scratch_q  <= '0;
    end else begin
      ready_en_q <= 1'b1;
      aw_held_q  <= aw_held_d;
      aw_addr_q  <= aw_addr_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      en_q       <= en_d;
      done_q     <= done_d;
      gate_q     <= gate_d;
      scratch_q  <= scratch_d;
    end
  end

endmodule

// File: tb/tb_freq_meas_axil_slave.sv
// Directed bench for freq_meas_axil_slave: register table, handshake ordering, strobes,
// measurement windows and asynchronous reset.
module tb_freq_meas_axil_slave;

  logic        ACLK;
  logic        ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        f_in;
  logic        done_irq;

  int checks = 0;
  int failures = 0;
  bit f_run = 0;
  int f_ph = 0;

  freq_meas_axil_slave dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .f_in          (f_in),
    .done_irq      (done_irq)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // f_in toggles every 2 ACLK cycles while f_run is set: period 4.
  always begin
    @(negedge ACLK);
    if (f_run) begin
      f_ph = f_ph + 1;
      if (f_ph % 2 == 0) f_in = ~f_in;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_go, w_go;
    int n = 0;
    resp = 2'bxx;
    @(negedge ACLK);
    S_AXI_AWADDR  = addr;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_WVALID  = 1'b1;
    S_AXI_BREADY  = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
      w_go  = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge ACLK);
      if (aw_go) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_go)  begin S_AXI_WVALID  = 1'b0; w_done  = 1; end
      n++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    if (!(aw_done && w_done)) begin
      timeout_fail("write_addr_data");
      return;
    end
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (S_AXI_BVALID) begin
      resp = S_AXI_BRESP;
      @(negedge ACLK);
    end else begin
      timeout_fail("write_resp");
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit ar_done = 0;
    bit ar_go;
    int n = 0;
    data = 'x;
    resp = 2'bxx;
    @(negedge ACLK);
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = 1'b1;
    while (!ar_done && n < 20) begin
      ar_go = S_AXI_ARVALID && S_AXI_ARREADY;
      @(negedge ACLK);
      if (ar_go) begin S_AXI_ARVALID = 1'b0; ar_done = 1; end
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    if (!ar_done) begin
      timeout_fail("read_addr");
      return;
    end
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (S_AXI_RVALID) begin
      data = S_AXI_RDATA;
      resp = S_AXI_RRESP;
      @(negedge ACLK);
    end else begin
      timeout_fail("read_data");
    end
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr, br;
    int          bv_cnt, n;
    bit          bv_extra;

    vecs[0] = '{addr: 4'h0, wdata: 32'h1, exp_bresp: 2'b00, exp_rdata: 32'h1};
    vecs[1] = '{addr: 4'h4, wdata: 32'h2, exp_bresp: 2'b00, exp_rdata: 32'h2};
    vecs[2] = '{addr: 4'h8, wdata: 32'h3, exp_bresp: 2'b10, exp_rdata: 32'h0};
    vecs[3] = '{addr: 4'hC, wdata: 32'h4, exp_bresp: 2'b00, exp_rdata: 32'h4};

    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    f_in = 1'b0;
    repeat (3) @(negedge ACLK);
    check32("reset_readys", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
    check32("reset_valids", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
    check32("reset_rdata", S_AXI_RDATA, 32'd0);
    check32("reset_done_irq", {31'd0, done_irq}, 32'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check32("post_reset_readys", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);

    // Register table: writes then reads back (CTRL first, before the first window ends).
    for (int i = 0; i < 4; i++) begin
      axi_write(vecs[i].addr, vecs[i].wdata, 4'hF, br);
      check32($sformatf("tbl_bresp_%0d", i), {30'd0, br}, {30'd0, vecs[i].exp_bresp});
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(vecs[i].addr, rd, rr);
      check32($sformatf("tbl_rdata_%0d", i), rd, vecs[i].exp_rdata);
      check32($sformatf("tbl_rresp_%0d", i), {30'd0, rr}, 32'd0);
    end
    axi_write(4'h0, 32'h100, 4'hF, br);

    // W ahead of AW, then a stalled B channel.
    @(negedge ACLK);
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h55AA_55AA; S_AXI_WSTRB = 4'hF;
    S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    check32("w_held_wready_1", {31'd0, S_AXI_WREADY}, 32'd0);
    @(negedge ACLK);
    check32("w_held_wready_2", {31'd0, S_AXI_WREADY}, 32'd0);
    check32("no_commit_without_aw", {31'd0, S_AXI_BVALID}, 32'd0);
    S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    check32("both_held_readys", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd0);
    bv_cnt = 0;
    repeat (5) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) bv_cnt++;
    end
    check32("bvalid_held_cycles", bv_cnt, 32'd5);
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    check32("bvalid_dropped", {31'd0, S_AXI_BVALID}, 32'd0);
    bv_extra = 0;
    repeat (3) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) bv_extra = 1;
    end
    check32("single_commit", {31'd0, bv_extra}, 32'd0);
    axi_read(4'hC, rd, rr);
    check32("w_before_aw_data", rd, 32'h55AA_55AA);

    // Byte strobes.
    axi_write(4'hC, 32'h1122_3344, 4'hF, br);
    axi_write(4'hC, 32'hAABB_CCDD, 4'b0010, br);
    check32("strb_bresp", {30'd0, br}, 32'd0);
    axi_read(4'hC, rd, rr);
    check32("strb_data", rd, 32'h1122_CC44);

    // Gate of 100 cycles with f_in period 4.
    axi_write(4'h4, 32'd100, 4'hF, br);
    f_run = 1;
    axi_write(4'h0, 32'h1, 4'hF, br);
    n = 0;
    while (!done_irq && n < 300) begin
      @(negedge ACLK);
      n++;
    end
    if (!done_irq) timeout_fail("first_window_done");
    check32("done_irq_set", {31'd0, done_irq}, 32'd1);
    axi_read(4'h8, rd, rr);
    checks++;
    if (rd < 32'd24 || rd > 32'd26) begin
      failures++;
      $display("FAIL result_25: got %0d expected 24..26", rd);
    end
    axi_read(4'h0, rd, rr);
    check32("ctrl_done_en", rd, 32'h101);
    axi_write(4'h0, 32'h101, 4'hF, br);
    check32("w1c_bresp", {30'd0, br}, 32'd0);
    axi_read(4'h0, rd, rr);
    check32("ctrl_after_w1c", rd, 32'h1);
    check32("done_irq_cleared", {31'd0, done_irq}, 32'd0);

    // GATE = 0 acts as a one-cycle window.
    f_run = 0;
    axi_write(4'h0, 32'h100, 4'hF, br);
    axi_write(4'h4, 32'h0, 4'hF, br);
    axi_write(4'h0, 32'h1, 4'hF, br);
    repeat (3) @(negedge ACLK);
    check32("gate0_done_irq", {31'd0, done_irq}, 32'd1);
    axi_read(4'h8, rd, rr);
    check32("gate0_result", rd, 32'd0);
    axi_write(4'h0, 32'h101, 4'hF, br);
    check32("gate0_set_wins_irq", {31'd0, done_irq}, 32'd1);
    axi_read(4'h0, rd, rr);
    check32("gate0_ctrl", rd, 32'h101);

    // Async reset with a read response pending and a window half done.
    axi_write(4'h4, 32'd100, 4'hF, br);
    f_run = 1;
    repeat (50) @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    S_AXI_ARADDR = 4'h4;
    S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check32("rvalid_before_reset", {31'd0, S_AXI_RVALID}, 32'd1);
    #2 ARESET = 1'b1;
    #1;
    check32("areset_readys", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
    check32("areset_valids", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
    check32("areset_rdata", S_AXI_RDATA, 32'd0);
    check32("areset_resps", {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
    check32("areset_done_irq", {31'd0, done_irq}, 32'd0);
    f_run = 0;
    @(negedge ACLK);
    ARESET = 1'b0;
    axi_read(4'h0, rd, rr);
    check32("rst_ctrl", rd, 32'h0);
    axi_read(4'h4, rd, rr);
    check32("rst_gate", rd, 32'h64);
    axi_read(4'h8, rd, rr);
    check32("rst_result", rd, 32'h0);
    axi_read(4'hC, rd, rr);
    check32("rst_scratch", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_meas_axil_slave.md
Name: freq_meas_axil_slave

Overview:
AXI4-Lite responder for the frequency-measurement IP. It terminates the control bus that the master VIP drives. It holds the control, gate and scratch registers and returns the measured edge count from an internal gated counter. One instance per freq_meas IP, sitting directly behind the block-design AXI port.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; four 32-bit registers.
CNT_WIDTH, 32, width of the edge counter and RESULT register; must be ≤ 32.

Ports:
ACLK  in  1  single clock for bus and measurement logic
ARESET  in  1  asynchronous, active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1
S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4 / S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1
S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH / S_AXI_ARPROT  in  3 (ignored)
S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1
S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1
f_in  in  1  asynchronous signal under measurement
done_irq  out  1  level; equals CTRL.DONE

Behaviour:
- Reset (async assert, sync release to ACLK):
  - All READY/VALID outputs are 0; BRESP, RRESP and RDATA are 0.
  - CTRL = 0; GATE = 0x0000_0064; RESULT = 0; SCRATCH = 0; counters and synchronizer are 0.
- Register map, decoded on ADDR[3:2]; ADDR[1:0] is ignored:
  - 0x0 CTRL: bit0 EN (RW); bit8 DONE (RO, sticky, write-1-to-clear); other bits read 0.
  - 0x4 GATE: RW, window length in ACLK cycles; a value of 0 is treated as 1.
  - 0x8 RESULT: RO. A write has no effect and returns BRESP = SLVERR (2'b10).
  - 0xC SCRATCH: RW.
- Write channel:
  - AW and W are accepted independently, in either order, one of each held at a time.
  - AWREADY = ~aw_held; WREADY = ~w_held.
  - When both are held and BVALID = 0, the write commits on that cycle and BVALID rises the next cycle. Both held flags clear on the commit.
  - The write is byte-masked by WSTRB.
  - BVALID holds until BREADY; no new commit happens while BVALID = 1.
- Read channel:
  - ARREADY = ~RVALID.
  - An AR handshake latches RDATA/RRESP, and RVALID rises the next cycle.
  - RVALID and RDATA hold until RREADY. RRESP is always OKAY.
- Same-cycle read and write commit to one register: the read returns the pre-write value.
- Measurement:
  - f_in passes through a 2-flop synchronizer. A rising edge is detected on the synchronized signal.
  - States: IDLE → RUN when EN = 1. In RUN, gate_cnt counts up each cycle and edge_cnt increments on each detected edge, saturating at all ones.
  - When gate_cnt reaches max(GATE,1) - 1, the block latches RESULT = edge_cnt plus that cycle's edge and sets DONE. The counters clear and the block stays in RUN, so windows are continuous.
  - EN cleared → IDLE immediately; counters clear and RESULT is retained.
  - A GATE write during RUN takes effect at the next window.
  - DONE set and a W1C write in the same cycle → DONE stays 1 (set wins).
- Reset mid-transaction: outstanding AW, W, B and R state is dropped, and the master must reissue.

Decomposition:
- Package freq_meas_pkg holds:
  - Register offsets: ADDR_CTRL, ADDR_GATE, ADDR_RESULT, ADDR_SCRATCH.
  - CTRL bit indices.
  - RESP_OKAY and RESP_SLVERR constants.
  - The state enum {IDLE, RUN} and the reset value of GATE.
- One sub-module, freq_meas_core: synchronizer, edge detect, gate and edge counters, RESULT latch and DONE set pulse. The AXI handshake and register file stay in the top.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to offsets 0x0,0x4,0x8,0xC, then read all four:
  - 0x0 reads 0x1. 0x4 reads 0x2. 0x8 reads 0x0, with SLVERR on its write. 0xC reads 0x4.
  - All other responses are OKAY.
- Present W two cycles before AW, with BREADY held low for 5 cycles:
  - Write commits once. BVALID stays high 5 cycles. AWREADY and WREADY stay low while held.
- Write WSTRB = 4'b0010 with data 0xAABBCCDD to SCRATCH = 0x11223344 → read returns 0x1122CC44.
- GATE = 100, EN = 1, f_in toggling every 2 ACLK (period 4) → after the first window RESULT = 25 ±1, DONE = 1 and done_irq = 1. Writing CTRL = 0x101 clears DONE and keeps EN = 1.
- GATE = 0, EN = 1, f_in static → DONE sets every cycle and RESULT = 0.
- Assert ARESET while RVALID = 1 and a window is half done → all outputs go to 0 asynchronously. Reads after release return the reset values, including GATE = 0x64.
